// File: rtl/bcd_counter_7seg.sv
// Multi-digit BCD up/down counter with registered active-low 7-segment outputs.
// Optional leading-zero blanking is enabled by defining BCD_COUNTER_LEADING_ZERO_BLANK_EN.
module bcd_counter_7seg #(
  parameter int NUM_DIGITS = 2,
  parameter int WRAP_MODE  = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Inc,
  input  logic                    i_Dec,
  input  logic                    i_Clear,
  output logic [4*NUM_DIGITS-1:0] o_Count_BCD,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Wrap
);

  localparam logic [4*NUM_DIGITS-1:0] COUNT_MAX = {NUM_DIGITS{4'h9}};
  localparam logic [4*NUM_DIGITS-1:0] COUNT_MIN = '0;
  localparam logic [6:0]              SEG_ZERO  = 7'h40;
  localparam logic [6:0]              SEG_BLANK = 7'h7F;

  logic                    inc_d_p0, dec_d_p0;
  logic                    inc_edge, dec_edge;
  logic [4*NUM_DIGITS-1:0] count_p1;
  logic                    wrap_p1;
  logic [7*NUM_DIGITS-1:0] seg_p2;

  // Active-low GFEDCBA patterns; codes 10..15 are unreachable and stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [4*NUM_DIGITS-1:0] bcd_inc(input logic [4*NUM_DIGITS-1:0] v);
    logic [4*NUM_DIGITS-1:0] r;
    logic                    carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [4*NUM_DIGITS-1:0] bcd_dec(input logic [4*NUM_DIGITS-1:0] v);
    logic [4*NUM_DIGITS-1:0] r;
    logic                    borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] display(input logic [4*NUM_DIGITS-1:0] v);
    logic [7*NUM_DIGITS-1:0] s;
`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
    logic blank;
    blank = 1'b1;
`endif
    s = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      s[7*k +: 7] = seg_decode(v[4*k +: 4]);
`ifdef BCD_COUNTER_LEADING_ZERO_BLANK_EN
      // Scanning from the top digit down; the first nonzero digit ends blanking.
      if (k > 0 && blank && v[4*k +: 4] == 4'd0) begin
        s[7*k +: 7] = SEG_BLANK;
      end else begin
        blank = 1'b0;
      end
`endif
    end
    return s;
  endfunction

  assign inc_edge = i_Inc & ~inc_d_p0;
  assign dec_edge = i_Dec & ~dec_d_p0;

  always_ff @(posedge i_Clk) begin
    // p0: previous input samples; loaded from the live inputs during reset too
    inc_d_p0 <= i_Inc;
    dec_d_p0 <= i_Dec;
    if (i_Reset) begin
      count_p1 <= '0;
      wrap_p1  <= 1'b0;
      seg_p2   <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      // p1: count and wrap pulse
      wrap_p1 <= 1'b0;
      if (i_Clear) begin
        count_p1 <= '0;
      end else if (inc_edge && !dec_edge) begin
        if (count_p1 != COUNT_MAX) begin
          count_p1 <= bcd_inc(count_p1);
        end else if (WRAP_MODE != 0) begin
          count_p1 <= bcd_inc(count_p1);
          wrap_p1  <= 1'b1;
        end
      end else if (dec_edge && !inc_edge) begin
        if (count_p1 != COUNT_MIN) begin
          count_p1 <= bcd_dec(count_p1);
        end else if (WRAP_MODE != 0) begin
          count_p1 <= bcd_dec(count_p1);
          wrap_p1  <= 1'b1;
        end
      end
      // p2: segment drive lags the count by one cycle
      seg_p2 <= display(count_p1);
    end
  end

  assign o_Count_BCD = count_p1;
  assign o_Wrap      = wrap_p1;
  assign o_Segments  = seg_p2;

endmodule

// File: doc/bcd_counter_7seg.md
BCD_COUNTER_7SEG -- requirements
Module: bcd_counter_7seg

Interface
REQ-001 The parameter NUM_DIGITS SHALL default to 2 and sets the number of BCD digits and displays, legal range 1..8.
REQ-002 The parameter WRAP_MODE SHALL default to 1; 1 means wrap-around, 0 means saturate at the limits.
REQ-003 The port i_Clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-004 The port i_Reset SHALL be an input, 1 bit wide, and is a synchronous, active-high reset.
REQ-005 The port i_Inc SHALL be an input, 1 bit wide: an already-debounced increment request; only a rising edge counts.
REQ-006 The port i_Dec SHALL be an input, 1 bit wide: an already-debounced decrement request; only a rising edge counts.
REQ-007 The port i_Clear SHALL be an input, 1 bit wide: a level-sensitive clear of the count to zero.
REQ-008 The port o_Count_BCD SHALL be an output, 4*NUM_DIGITS bits wide: the registered count, with digit 0 (ones) in bits [3:0].
REQ-009 The port o_Segments SHALL be an output, 7*NUM_DIGITS bits wide: active-low segments, with bits [7k+0..7k+6] = A..G of digit k.
REQ-010 The port o_Wrap SHALL be an output, 1 bit wide: a one-cycle pulse on wrap-around in either direction.

Function
REQ-011 The block SHALL detect edges by comparing each of i_Inc and i_Dec with its value registered one cycle earlier; a rising edge is current=1 with previous=0.
REQ-012 The count SHALL update in the cycle after the rising edge appears on the input.
REQ-013 An increment SHALL add 1 in BCD: a digit at 9 becomes 0 and carries into the next digit; digits never hold 10..15.
REQ-014 A decrement SHALL subtract 1 in BCD: a digit at 0 becomes 9 and borrows from the next digit.
REQ-015 Priority SHALL be i_Reset > i_Clear > (inc/dec edge); while i_Clear=1 the count is 0 and edges are discarded.
REQ-016 Simultaneous rising edges on i_Inc and i_Dec in the same cycle SHALL leave the count unchanged and SHALL NOT pulse o_Wrap.
REQ-017 With WRAP_MODE=1, an increment at all-9s SHALL give all-0s and a decrement at all-0s SHALL give all-9s; o_Wrap=1 in the same cycle the wrapped count appears.
REQ-018 With WRAP_MODE=0, an increment at all-9s and a decrement at all-0s SHALL leave the count unchanged, and o_Wrap SHALL stay 0.
REQ-019 o_Segments SHALL be registered and SHALL reflect o_Count_BCD one cycle later.
REQ-020 Digit decoding SHALL use the standard 0-9 patterns (1 = unlit): 0 lights ABCDEF; 1 lights BC; 7 lights ABC; 9 lights ABCDFG.
REQ-021 Illegal digit codes SHALL NOT be reachable; the decoder maps them to all segments unlit.

Reset
REQ-022 While i_Reset=1 at a rising clock edge: o_Count_BCD=0, o_Wrap=0, o_Segments=0 pattern for every digit at the next edge.
REQ-023 During reset the edge-detect registers SHALL load the current i_Inc and i_Dec, so an input held high through reset release produces no count.
REQ-024 Reset asserted mid-operation (including the cycle an edge arrives) SHALL discard that edge.

Configuration
REQ-025 With the macro BCD_COUNTER_LEADING_ZERO_BLANK_EN defined, every digit k>0 that is 0 and has all higher digits 0 SHALL be fully unlit (all segment bits 1); digit 0 is always shown.
REQ-026 Without BCD_COUNTER_LEADING_ZERO_BLANK_EN, all digits SHALL always display their value; o_Count_BCD is unaffected either way.

Verification
REQ-027 Reset; NUM_DIGITS=2; 10 i_Inc pulses -> o_Count_BCD=0x10 and o_Segments=0x40 pattern for 1/0, i.e. {digit1 = 1111001, digit0 = 1000000} as GFEDCBA.
REQ-028 WRAP_MODE=1, count 0x99, one i_Inc edge -> count 0x00 with o_Wrap high exactly 1 cycle; one i_Dec edge -> count 0x99 with o_Wrap pulse.
REQ-029 WRAP_MODE=0, count 0x99 with i_Inc edge -> stays 0x99; count 0x00 with i_Dec edge -> stays 0x00; o_Wrap never asserted.
REQ-030 i_Inc and i_Dec rising in the same cycle at count 0x42 -> stays 0x42; i_Clear with an i_Inc edge -> 0x00.
REQ-031 i_Inc held high through i_Reset deassertion -> count stays 0x00 until i_Inc falls and rises again.
REQ-032 With the macro defined, NUM_DIGITS=3, count 0x007 -> digits 2 and 1 all unlit, digit 0 shows 7; count 0x000 -> only digit 0 shows 0.
